// File: rtl/imem_program_encoder_if.sv
// Instruction-beat handshake and IMEM write-port bundle for imem_program_encoder.
// The master drives symbolic beats and observes the IMEM write port; the slave is
// the encoder itself.
interface imem_program_encoder_if #(
    parameter int ADDR_W = 8
);
    // Symbolic instruction beat channel
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;

    // Instruction-memory write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_kind,
        output in_rs,
        output in_rt,
        output in_rd,
        output in_funct,
        output in_imm,
        output in_target,
        output in_last,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_kind,
        input  in_rs,
        input  in_rt,
        input  in_rd,
        input  in_funct,
        input  in_imm,
        input  in_target,
        input  in_last,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: packs symbolic instruction beats into 32-bit MIPS words and
// writes them sequentially into IMEM starting at a programmable base address.
// Optional build macro IMEM_ENC_FUNCT_CHECK_EN: when defined, R-type beats whose
// funct is not ADD/SUB/AND/OR/XOR/SLT are rejected as illegal.
module imem_program_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    imem_program_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        K_R    = 4'd0,
        K_J    = 4'd1,
        K_BEQ  = 4'd2,
        K_ADDI = 4'd3,
        K_SLTI = 4'd4,
        K_ANDI = 4'd5,
        K_ORI  = 4'd6,
        K_XORI = 4'd7,
        K_LW   = 4'd8,
        K_SW   = 4'd9
    } kind_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    localparam logic [ADDR_W-1:0] PTR_INC = 1;
    localparam logic [ADDR_W:0]   WC_INC  = 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;

    logic                enc_legal;
    logic [31:0]         enc_word;
    logic [5:0]          i_op;

    // Encode the current beat and flag kinds (or functs) that have no encoding
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        i_op      = OP_ADDI;
        case (bus.in_kind)
            K_R: begin
                enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
`ifdef IMEM_ENC_FUNCT_CHECK_EN
                case (bus.in_funct)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b100110, 6'b101010: begin
                        enc_legal = 1'b1;
                    end
                    default: begin
                        enc_legal = 1'b0;
                    end
                endcase
`endif
            end
            K_J: begin
                enc_word = {OP_J, bus.in_target};
            end
            K_BEQ, K_ADDI, K_SLTI, K_ANDI, K_ORI, K_XORI, K_LW, K_SW: begin
                case (bus.in_kind)
                    K_BEQ:   i_op = OP_BEQ;
                    K_ADDI:  i_op = OP_ADDI;
                    K_SLTI:  i_op = OP_SLTI;
                    K_ANDI:  i_op = OP_ANDI;
                    K_ORI:   i_op = OP_ORI;
                    K_XORI:  i_op = OP_XORI;
                    K_LW:    i_op = OP_LW;
                    default: i_op = OP_SW;
                endcase
                enc_word = {i_op, bus.in_rs, bus.in_rt, bus.in_imm};
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // Next-state logic: load control, write-port update and error capture
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_count_d = word_count_q;
        err_code_d   = err_code_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (!enc_legal) begin
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_ERR;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ptr_q;
                        imem_wdata_d = enc_word;
                        word_count_d = word_count_q + WC_INC;
                        // The top word is still written; only a further beat would overflow,
                        // so ptr is parked there instead of wrapping.
                        if (ptr_q != '1) begin
                            ptr_d = ptr_q + PTR_INC;
                        end
                        if (bus.in_last) begin
                            state_d = S_DONE;
                        end else if (ptr_q == '1) begin
                            err_code_d = ERR_OVERFLOW;
                            state_d    = S_ERR;
                        end
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERR all re-arm on start; beats are not accepted here
                if (start) begin
                    ptr_d        = base_addr;
                    word_count_d = '0;
                    err_code_d   = ERR_NONE;
                    state_d      = S_LOAD;
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            word_count_q <= '0;
            err_code_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            word_count_q <= word_count_d;
            err_code_q   <= err_code_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
// Directed testbench for imem_program_encoder: a default-width instance (ADDR_W=8)
// for encoding, sequencing and error cases, and an ADDR_W=4 instance for overflow.
module tb_imem_program_encoder;

    logic clk;
    logic rst_n;

    logic       start8;
    logic [7:0] base8;
    logic       busy8, done8, err8;
    logic [1:0] err_code8;
    logic [8:0] wc8;

    logic       start4;
    logic [3:0] base4;
    logic       busy4, done4, err4;
    logic [1:0] err_code4;
    logic [4:0] wc4;

    int checks;
    int failures;

    imem_program_encoder_if #(.ADDR_W(8)) bus8 ();
    imem_program_encoder_if #(.ADDR_W(4)) bus4 ();

    imem_program_encoder #(.ADDR_W(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .base_addr  (base8),
        .bus        (bus8),
        .busy       (busy8),
        .done       (done8),
        .err        (err8),
        .err_code   (err_code8),
        .word_count (wc8)
    );

    imem_program_encoder #(.ADDR_W(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .base_addr  (base4),
        .bus        (bus4),
        .busy       (busy4),
        .done       (done4),
        .err        (err4),
        .err_code   (err_code4),
        .word_count (wc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat8(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm,
                         input logic [25:0] tg, input logic last);
        bus8.in_valid  = 1'b1;
        bus8.in_kind   = k;
        bus8.in_rs     = rs;
        bus8.in_rt     = rt;
        bus8.in_rd     = rd;
        bus8.in_funct  = f;
        bus8.in_imm    = imm;
        bus8.in_target = tg;
        bus8.in_last   = last;
    endtask

    task automatic beat4(input logic [15:0] imm, input logic last);
        bus4.in_valid  = 1'b1;
        bus4.in_kind   = 4'd3;
        bus4.in_rs     = 5'd0;
        bus4.in_rt     = 5'd8;
        bus4.in_rd     = 5'd0;
        bus4.in_funct  = 6'd0;
        bus4.in_imm    = imm;
        bus4.in_target = 26'd0;
        bus4.in_last   = last;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start8   = 1'b0;
        base8    = 8'h00;
        start4   = 1'b0;
        base4    = 4'h0;
        beat8(4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        bus8.in_valid = 1'b0;
        beat4(16'd0, 1'b0);
        bus4.in_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus8.in_ready, 0);
        check("rst_we", bus8.imem_we, 0);
        check("rst_addr", bus8.imem_addr, 0);
        check("rst_wdata", bus8.imem_wdata, 0);
        check("rst_status", {busy8, done8, err8, err_code8}, 0);
        check("rst_wc", wc8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI with last at base 0x10
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h10;
        @(posedge clk); #1;
        check("t1_busy", busy8, 1);
        check("t1_in_ready", bus8.in_ready, 1);
        check("t1_wc0", wc8, 0);
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd3, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        @(posedge clk); #1;
        check("t1_we", bus8.imem_we, 1);
        check("t1_addr", bus8.imem_addr, 8'h10);
        check("t1_wdata", bus8.imem_wdata, 32'h20080005);
        check("t1_done", {busy8, done8, err8}, 3'b010);
        check("t1_wc", wc8, 1);
        check("t1_ready_off", bus8.in_ready, 0);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        check("t1_we_pulse", bus8.imem_we, 0);
        check("t1_addr_hold", bus8.imem_addr, 8'h10);
        check("t1_wdata_hold", bus8.imem_wdata, 32'h20080005);
        check("t1_done_hold", done8, 1);

        // R, LW, SW back-to-back at 0x20; a start during LOAD is ignored
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h20;
        @(posedge clk); #1;
        check("t2_busy", busy8, 1);
        check("t2_wc0", wc8, 0);
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
        @(posedge clk); #1;
        check("t2_r_we", bus8.imem_we, 1);
        check("t2_r_addr", bus8.imem_addr, 8'h20);
        check("t2_r_wdata", bus8.imem_wdata, 32'h01095020);
        check("t2_r_wc", wc8, 1);
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h77;
        beat8(4'd8, 5'd8, 5'd9, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
        @(posedge clk); #1;
        check("t2_lw_we", bus8.imem_we, 1);
        check("t2_lw_addr", bus8.imem_addr, 8'h21);
        check("t2_lw_wdata", bus8.imem_wdata, 32'h8D090004);
        check("t2_lw_wc", wc8, 2);
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd9, 5'd8, 5'd9, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
        @(posedge clk); #1;
        check("t2_sw_we", bus8.imem_we, 1);
        check("t2_sw_addr", bus8.imem_addr, 8'h22);
        check("t2_sw_wdata", bus8.imem_wdata, 32'hAD090004);
        check("t2_sw_wc", wc8, 3);
        check("t2_done", {busy8, done8, err8}, 3'b010);
        @(negedge clk);
        bus8.in_valid = 1'b0;

        // J and BEQ at 0x30
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h30;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0);
        @(posedge clk); #1;
        check("t3_j_addr", bus8.imem_addr, 8'h30);
        check("t3_j_wdata", bus8.imem_wdata, 32'h08000010);
        @(negedge clk);
        beat8(4'd2, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
        @(posedge clk); #1;
        check("t3_beq_addr", bus8.imem_addr, 8'h31);
        check("t3_beq_wdata", bus8.imem_wdata, 32'h1109FFFF);
        check("t3_done", done8, 1);
        @(negedge clk);
        bus8.in_valid = 1'b0;

        // R with funct 0x3F at 0x38
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h38;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd0, 5'd8, 5'd9, 5'd10, 6'h3F, 16'd0, 26'd0, 1'b1);
        @(posedge clk); #1;
`ifdef IMEM_ENC_FUNCT_CHECK_EN
        check("t4_we", bus8.imem_we, 0);
        check("t4_err", {busy8, done8, err8, err_code8}, 5'b00101);
        check("t4_wc", wc8, 0);
`else
        check("t4_we", bus8.imem_we, 1);
        check("t4_addr", bus8.imem_addr, 8'h38);
        check("t4_wdata", bus8.imem_wdata, 32'h0109503F);
        check("t4_done", {busy8, done8, err8, err_code8}, 5'b01000);
`endif
        @(negedge clk);
        bus8.in_valid = 1'b0;

        // Illegal kind mid-load at 0x40
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h40;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        beat8(4'd3, 5'd0, 5'd8, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0);
        @(posedge clk); #1;
        check("t5_first_addr", bus8.imem_addr, 8'h40);
        @(negedge clk);
        beat8(4'd12, 5'd1, 5'd2, 5'd3, 6'd0, 16'd1, 26'd0, 1'b0);
        @(posedge clk); #1;
        check("t5_we", bus8.imem_we, 0);
        check("t5_err", {busy8, done8, err8, err_code8}, 5'b00101);
        check("t5_in_ready", bus8.in_ready, 0);
        check("t5_wc", wc8, 1);
        check("t5_addr_hold", bus8.imem_addr, 8'h40);
        // Restart with a valid beat present: the beat must not be taken this cycle
        @(negedge clk);
        start8 = 1'b1;
        base8  = 8'h48;
        beat8(4'd3, 5'd0, 5'd8, 5'd0, 6'd0, 16'd9, 26'd0, 1'b0);
        @(posedge clk); #1;
        check("t5_restart", {busy8, done8, err8, err_code8}, 5'b10000);
        check("t5_restart_we", bus8.imem_we, 0);
        check("t5_restart_wc", wc8, 0);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("t5_next_addr", bus8.imem_addr, 8'h48);
        check("t5_next_wdata", bus8.imem_wdata, 32'h20080009);
        check("t5_next_wc", wc8, 1);

        // Asynchronous reset in the middle of a load
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_we", bus8.imem_we, 0);
        check("t6_addr", bus8.imem_addr, 0);
        check("t6_wdata", bus8.imem_wdata, 0);
        check("t6_in_ready", bus8.in_ready, 0);
        check("t6_status", {busy8, done8, err8, err_code8}, 0);
        check("t6_wc", wc8, 0);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Overflow on the ADDR_W=4 instance
        @(negedge clk);
        start4 = 1'b1;
        base4  = 4'd14;
        @(posedge clk); #1;
        @(negedge clk);
        start4 = 1'b0;
        beat4(16'd5, 1'b0);
        @(posedge clk); #1;
        check("t7_addr14", bus4.imem_addr, 4'd14);
        check("t7_wdata14", bus4.imem_wdata, 32'h20080005);
        check("t7_wc1", wc4, 1);
        @(negedge clk);
        beat4(16'd6, 1'b0);
        @(posedge clk); #1;
        check("t7_we15", bus4.imem_we, 1);
        check("t7_addr15", bus4.imem_addr, 4'd15);
        check("t7_wdata15", bus4.imem_wdata, 32'h20080006);
        check("t7_ovf", {busy4, done4, err4, err_code4}, 5'b00110);
        check("t7_wc2", wc4, 2);
        check("t7_in_ready", bus4.in_ready, 0);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        check("t7_no_more_we", bus4.imem_we, 0);

        // Last beat at the top address is legal
        @(negedge clk);
        start4 = 1'b1;
        base4  = 4'd15;
        @(posedge clk); #1;
        check("t8_cleared", {busy4, done4, err4, err_code4}, 5'b10000);
        @(negedge clk);
        start4 = 1'b0;
        beat4(16'd3, 1'b1);
        @(posedge clk); #1;
        check("t8_addr", bus4.imem_addr, 4'd15);
        check("t8_wdata", bus4.imem_wdata, 32'h20080003);
        check("t8_done", {busy4, done4, err4, err_code4}, 5'b01000);
        check("t8_wc", wc4, 1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
- Encoder and writer for instruction memory: the reverse of the opcode decoder.
- Accepts symbolic instruction beats (kind plus register/immediate fields) over a valid/ready handshake and packs each into a 32-bit MIPS word.
- Writes words sequentially into the instruction-memory write port, starting at a programmable base address.
- Used by testbenches and the boot loader to place programs in IMEM before the core leaves reset or halt.

Parameters:
- ADDR_W, 8, IMEM word-address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load at base_addr
- base_addr  in  ADDR_W  first word address of the load, sampled on start
- in_valid  in  1  instruction beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_kind  in  4  0=R, 1=J, 2=BEQ, 3=ADDI, 4=SLTI, 5=ANDI, 6=ORI, 7=XORI, 8=LW, 9=SW; 10-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type funct
- in_imm  in  16  I-type immediate or offset
- in_target  in  26  J target
- in_last  in  1  marks the final beat of the program
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- err  out  1  high in ERR
- err_code  out  2  0=none, 1=illegal kind/funct, 2=overflow
- word_count  out  ADDR_W+1  words written in the current load

Behaviour:
- FSM states: IDLE, LOAD, DONE, ERR. Reset enters IDLE.
- Reset values: all outputs 0, including in_ready, imem_we, imem_addr, imem_wdata, word_count and err_code.
- start in IDLE, DONE or ERR:
  - ptr <= base_addr; word_count <= 0; err_code <= 0; state <= LOAD.
  - start is ignored while in LOAD.
- in_ready = (state == LOAD), combinational from state. Throughput is one word per cycle.
- Encoding opcodes: R 000000, J 000010, BEQ 000100, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011.
- Word formats:
  - R: {op, rs, rt, rd, 5'b0, funct}; shamt is always 0.
  - I (BEQ/ADDI/SLTI/ANDI/ORI/XORI/LW/SW): {op, rs, rt, imm}; in_rd and in_funct are ignored.
  - J: {op, target}.
- Legal beat accepted in cycle N: in cycle N+1, imem_we=1, imem_addr=ptr, imem_wdata=encoded word. ptr increments and word_count increments.
- imem_we is a one-cycle pulse per accepted beat. When no beat is accepted, imem_we=0 and imem_addr/imem_wdata hold their last values.
- in_last on a legal beat: the word is written, then state <= DONE.
- Illegal in_kind (10-15): no write; err_code <= 1; state <= ERR. ptr and word_count are unchanged.
- Overflow: a legal non-last beat accepted with ptr == 2**ADDR_W-1 is written, then err_code <= 2 and state <= ERR. ptr never wraps.
- A last beat at ptr == 2**ADDR_W-1 is legal and ends in DONE.
- DONE and ERR hold their state, and done/err, until the next start. in_ready=0 in both.
- start asserted together with in_valid in IDLE/DONE/ERR: the beat is not accepted (in_ready is 0 that cycle).
- rst_n low mid-load: immediate return to IDLE with outputs cleared. Partial IMEM contents are left as written.

Optional Feature:
- Macro: IMEM_ENC_FUNCT_CHECK_EN.
- Defined: an R-type funct outside {100000, 100010, 100100, 100101, 100110, 101010} is illegal (err_code=1, no write).
- Undefined: any funct is encoded verbatim.

Test Plan:
- start, base 0x10; ADDI rs=0 rt=8 imm=5 with last -> one cycle later we=1, addr=0x10, wdata=0x20080005; then done=1, word_count=1.
- R rs=8 rt=9 rd=10 funct=0x20, then LW rs=8 rt=9 imm=4, then SW rs=8 rt=9 imm=4 with last, back-to-back -> 0x01095020, 0x8D090004, 0xAD090004 at consecutive addresses on consecutive cycles.
- J target=0x10 -> 0x08000010; BEQ rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF.
- in_kind=12 mid-load -> no write; err=1, err_code=1, in_ready=0; a subsequent start clears err.
- ADDR_W=4, base 14, two non-last beats -> writes at 14 and 15, then err_code=2, word_count=2.
- rst_n low during LOAD -> all outputs 0 and IDLE within the same cycle.
- With IMEM_ENC_FUNCT_CHECK_EN: R funct=0x3F -> err_code=1. Without it: written as 0x0109503F for the fields above.
